// File: rtl/npc_trap_pkg.sv
// Shared constants and types for the commit-side trap monitor.
package npc_trap_pkg;

    localparam int XLEN = 64;

    // ebreak encoding as seen on the commit stream
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    // Reason codes reported on a0 for traps that do not come from ebreak
    localparam logic [XLEN-1:0] TRAP_HANG    = 64'd1;
    localparam logic [XLEN-1:0] TRAP_ILLEGAL = 64'd2;
    localparam logic [XLEN-1:0] TRAP_LIMIT   = 64'd3;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        EXIT  = 2'b10
    } trap_state_e;

    // True when the retiring encoding is exactly ebreak
    function automatic logic is_ebreak(input logic [31:0] inst);
        return (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/trap_watchdog.sv
// Saturating no-commit counter. expired is raised in the cycle the count
// would reach TIMEOUT, unless a commit (clear) lands in that same cycle.
module trap_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] LAST_C = CW'(LAST);
    localparam logic [CW-1:0] TOP_C  = CW'(TIMEOUT);
    localparam logic          WD_EN  = (TIMEOUT != 0);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;

    // Next count: clear on commit, otherwise count up to TIMEOUT and hold
    always_comb begin
        count_s = count_r;
        if (clear) begin
            count_s = {CW{1'b0}};
        end else if (enable && (count_r != TOP_C)) begin
            count_s = count_r + CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Expiry fires on the idle cycle that completes TIMEOUT cycles without a commit
    always_comb begin
        expired = WD_EN & enable & ~clear & (count_r == LAST_C);
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

endmodule

// File: rtl/trap_monitor.sv
// Retirement-side trap detector feeding the DEBUG simulation-exit block.
// Detects illegal / ebreak / instruction-limit / hang, latches the
// terminating context, halts the core, drains, then raises exit.
module trap_monitor
    import npc_trap_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 4096,
    parameter int unsigned MAX_INSTR    = 0,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [31:0]     commit_inst,
    input  logic            commit_illegal,
    input  logic [XLEN-1:0] rf_a0,
    output logic            halt,
    output logic            exit,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] a0,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instret_cnt
);

    localparam int unsigned     DW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]   DRAIN_INIT  = DW'(DRAIN_CYCLES - 1);
    localparam logic [XLEN-1:0] MAX_INSTR_C = XLEN'(MAX_INSTR);
    localparam logic            LIMIT_EN    = (MAX_INSTR != 0);

    trap_state_e     state_r, state_s;
    logic            halt_r, halt_s;
    logic            exit_r, exit_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] a0_r, a0_s;
    logic [31:0]     inst_r, inst_s;
    logic [XLEN-1:0] last_pc_r, last_pc_s;
    logic [31:0]     last_inst_r, last_inst_s;
    logic [DW-1:0]   drain_r, drain_s;
    logic [XLEN-1:0] cycle_r, cycle_s;
    logic [XLEN-1:0] instret_r, instret_s;

    logic run_s;
    logic commit_s;
    logic illegal_s;
    logic ebreak_s;
    logic limit_s;
    logic hang_s;
    logic trap_s;

    // Trap source decode; commits only count while running
    always_comb begin
        run_s     = (state_r == RUN);
        commit_s  = run_s & commit_valid;
        illegal_s = commit_s & commit_illegal;
        ebreak_s  = commit_s & is_ebreak(commit_inst);
        limit_s   = LIMIT_EN & commit_s & ((instret_r + 64'd1) == MAX_INSTR_C)
                    & ~illegal_s & ~ebreak_s;
        trap_s    = illegal_s | ebreak_s | limit_s | hang_s;
    end

    trap_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (commit_s),
        .enable  (run_s),
        .expired (hang_s)
    );

    // Next-state and next-output logic for the RUN -> DRAIN -> EXIT sequence
    always_comb begin
        state_s     = state_r;
        halt_s      = halt_r;
        exit_s      = exit_r;
        pc_s        = pc_r;
        a0_s        = a0_r;
        inst_s      = inst_r;
        last_pc_s   = last_pc_r;
        last_inst_s = last_inst_r;
        drain_s     = drain_r;

        case (state_r)
            RUN: begin
                if (commit_s) begin
                    last_pc_s   = commit_pc;
                    last_inst_s = commit_inst;
                end else begin
                    last_pc_s   = last_pc_r;
                    last_inst_s = last_inst_r;
                end

                if (illegal_s) begin
                    pc_s   = commit_pc;
                    inst_s = commit_inst;
                    a0_s   = TRAP_ILLEGAL;
                end else if (ebreak_s) begin
                    pc_s   = commit_pc;
                    inst_s = commit_inst;
                    a0_s   = rf_a0;
                end else if (limit_s) begin
                    pc_s   = commit_pc;
                    inst_s = commit_inst;
                    a0_s   = TRAP_LIMIT;
                end else if (hang_s) begin
                    pc_s   = last_pc_r;
                    inst_s = last_inst_r;
                    a0_s   = TRAP_HANG;
                end else begin
                    pc_s   = pc_r;
                    inst_s = inst_r;
                    a0_s   = a0_r;
                end

                if (trap_s) begin
                    state_s = DRAIN;
                    halt_s  = 1'b1;
                    drain_s = DRAIN_INIT;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                halt_s = 1'b1;
                if (drain_r == {DW{1'b0}}) begin
                    state_s = EXIT;
                    exit_s  = 1'b1;
                end else begin
                    drain_s = drain_r - DW'(1);
                    exit_s  = 1'b0;
                end
            end
            EXIT: begin
                halt_s = 1'b1;
                exit_s = 1'b1;
            end
            default: begin
                // Corrupted state: stop the core rather than resume execution
                state_s = EXIT;
                halt_s  = 1'b1;
                exit_s  = 1'b1;
            end
        endcase
    end

    // Statistics counters: cycles freeze in EXIT, instret counts RUN commits
    always_comb begin
        if (state_r == EXIT) begin
            cycle_s = cycle_r;
        end else begin
            cycle_s = cycle_r + 64'd1;
        end
        if (commit_s) begin
            instret_s = instret_r + 64'd1;
        end else begin
            instret_s = instret_r;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Trap context, control outputs and drain counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_r      <= 1'b0;
            exit_r      <= 1'b0;
            pc_r        <= 64'd0;
            a0_r        <= 64'd0;
            inst_r      <= 32'd0;
            last_pc_r   <= 64'd0;
            last_inst_r <= 32'd0;
            drain_r     <= {DW{1'b0}};
        end else begin
            halt_r      <= halt_s;
            exit_r      <= exit_s;
            pc_r        <= pc_s;
            a0_r        <= a0_s;
            inst_r      <= inst_s;
            last_pc_r   <= last_pc_s;
            last_inst_r <= last_inst_s;
            drain_r     <= drain_s;
        end
    end

    // Cycle and retired-instruction counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_r   <= 64'd0;
            instret_r <= 64'd0;
        end else begin
            cycle_r   <= cycle_s;
            instret_r <= instret_s;
        end
    end

    assign halt        = halt_r;
    assign exit        = exit_r;
    assign pc          = pc_r;
    assign a0          = a0_r;
    assign inst        = inst_r;
    assign cycle_cnt   = cycle_r;
    assign instret_cnt = instret_r;

endmodule

// File: tb/tb_trap_monitor.sv
// Scoreboard bench for trap_monitor. Two instances: u_dut0 (hang watchdog
// of 16, no limit) and u_dut1 (limit of 3, watchdog off). Stimulus pushes
// the expected exit record; a negedge monitor pops it when exit rises.
module tb_trap_monitor;

    localparam int DR = 8;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_illegal;
    logic [63:0] rf_a0;
    int          sel;
    logic        cv0, cv1;

    logic        halt0, exit0, halt1, exit1;
    logic [63:0] pc0, a00, cyc0, ins0, pc1, a01, cyc1, ins1;
    logic [31:0] inst0, inst1;

    always #5 clock = ~clock;

    assign cv0 = commit_valid & (sel == 0);
    assign cv1 = commit_valid & (sel == 1);

    trap_monitor #(.TIMEOUT(16), .MAX_INSTR(0), .DRAIN_CYCLES(DR)) u_dut0 (
        .clock(clock), .reset(reset), .commit_valid(cv0), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_illegal(commit_illegal), .rf_a0(rf_a0),
        .halt(halt0), .exit(exit0), .pc(pc0), .a0(a00), .inst(inst0),
        .cycle_cnt(cyc0), .instret_cnt(ins0)
    );

    trap_monitor #(.TIMEOUT(0), .MAX_INSTR(3), .DRAIN_CYCLES(DR)) u_dut1 (
        .clock(clock), .reset(reset), .commit_valid(cv1), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_illegal(commit_illegal), .rf_a0(rf_a0),
        .halt(halt1), .exit(exit1), .pc(pc1), .a0(a01), .inst(inst1),
        .cycle_cnt(cyc1), .instret_cnt(ins1)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] a0;
        logic [31:0] inst;
        logic [63:0] instret;
        int          halt_cyc;
        int          exit_cyc;
        logic [63:0] cycles;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rst_rel = 0;
    int   halt_seen = 0;
    logic halt_prev = 1'b0;
    logic exit_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: record halt rise, compare full context when exit rises
    always @(negedge clock) begin : mon
        logic        h, e;
        logic [63:0] p, a, ir, cc;
        logic [31:0] in;
        exp_t        ex;
        if (sel == 0) begin
            h = halt0; e = exit0; p = pc0; a = a00; in = inst0; ir = ins0; cc = cyc0;
        end else begin
            h = halt1; e = exit1; p = pc1; a = a01; in = inst1; ir = ins1; cc = cyc1;
        end
        if (h && !halt_prev) halt_seen = cyc;
        if (e && !exit_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_exit: dut %0d exit at cycle %0d, none expected", sel, cyc);
            end else begin
                ex = exp_q.pop_front();
                chk("exit_pc", p, ex.pc);
                chk("exit_a0", a, ex.a0);
                chk("exit_inst", {32'd0, in}, {32'd0, ex.inst});
                chk("instret_cnt", ir, ex.instret);
                chk("halt_cycle", 64'(halt_seen), 64'(ex.halt_cyc));
                chk("exit_cycle", 64'(cyc), 64'(ex.exit_cyc));
                chk("cycle_cnt", cc, ex.cycles);
            end
        end
        halt_prev = h;
        exit_prev = e;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int s);
        reset = 1'b0;
        commit_valid = 1'b0;
        commit_illegal = 1'b0;
        sel = s;
        step();
        step();
        reset = 1'b1;
        rst_rel = cyc;
    endtask

    task automatic commit(input logic [63:0] p, input logic [31:0] i, input logic ill,
                          input logic [63:0] a, output int t);
        commit_valid = 1'b1;
        commit_pc = p;
        commit_inst = i;
        commit_illegal = ill;
        rf_a0 = a;
        t = cyc;
        step();
        commit_valid = 1'b0;
        commit_illegal = 1'b0;
    endtask

    // Trap detected in slot t: halt at t+1, exit at t+1+DR
    task automatic expect_trap(input logic [63:0] p, input logic [63:0] a, input logic [31:0] i,
                               input logic [63:0] ir, input int t);
        exp_t ex;
        ex.pc = p; ex.a0 = a; ex.inst = i; ex.instret = ir;
        ex.halt_cyc = t + 1;
        ex.exit_cyc = t + 1 + DR;
        ex.cycles = 64'(t + 1 + DR - rst_rel);
        exp_q.push_back(ex);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL exit_timeout: got no exit after %0d cycles, expected exit", n);
            exp_q.delete();
        end
        step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_halt"}, {63'd0, halt0}, 64'd0);
        chk({tag, "_exit"}, {63'd0, exit0}, 64'd0);
        chk({tag, "_pc"}, pc0, 64'd0);
        chk({tag, "_a0"}, a00, 64'd0);
        chk({tag, "_inst"}, {32'd0, inst0}, 64'd0);
        chk({tag, "_cycle"}, cyc0, 64'd0);
        chk({tag, "_instret"}, ins0, 64'd0);
    endtask

    initial begin : watchdog_timer
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int t;
        logic [63:0] frozen;
        reset = 1'b1;
        sel = 0;
        commit_valid = 1'b0;
        commit_pc = 64'd0;
        commit_inst = 32'd0;
        commit_illegal = 1'b0;
        rf_a0 = 64'd0;
        #1 reset = 1'b0;
        step();
        step();
        chk_zero("reset");
        chk("reset_halt1", {63'd0, halt1}, 64'd0);
        chk("reset_exit1", {63'd0, exit1}, 64'd0);

        // ebreak with a0 = 0 and a0 = 1
        for (int v = 0; v < 2; v++) begin
            do_reset(0);
            for (int k = 0; k < 4; k++) commit(64'h8000_0000 + 64'(4 * k), NOP, 1'b0, 64'hdead, t);
            commit(64'h8000_0010, EBRK, 1'b0, 64'(v), t);
            expect_trap(64'h8000_0010, 64'(v), EBRK, 64'd5, t);
            wait_done();
        end

        // illegal wins over an ebreak encoding
        do_reset(0);
        commit(64'h8000_0020, EBRK, 1'b1, 64'h77, t);
        expect_trap(64'h8000_0020, 64'd2, EBRK, 64'd1, t);
        wait_done();

        // hang after 16 idle cycles
        do_reset(0);
        commit(64'h8000_0100, NOP, 1'b0, 64'd0, t);
        expect_trap(64'h8000_0100, 64'd1, NOP, 64'd1, t + 16);
        wait_done();

        // commit on the cycle the watchdog would expire: no hang, later ebreak
        do_reset(0);
        commit(64'h8000_0200, NOP, 1'b0, 64'd0, t);
        repeat (15) step();
        commit(64'h8000_0204, NOP, 1'b0, 64'd0, t);
        repeat (3) step();
        commit(64'h8000_0208, EBRK, 1'b0, 64'h55, t);
        expect_trap(64'h8000_0208, 64'h55, EBRK, 64'd3, t);
        wait_done();

        // instruction limit of 3; commits during DRAIN are ignored
        do_reset(1);
        commit(64'h8000_0300, NOP, 1'b0, 64'd0, t);
        commit(64'h8000_0304, NOP, 1'b0, 64'd0, t);
        commit(64'h8000_0308, 32'h0050_0093, 1'b0, 64'd0, t);
        expect_trap(64'h8000_0308, 64'd3, 32'h0050_0093, 64'd3, t);
        commit(64'h8000_030c, NOP, 1'b0, 64'd0, t);
        commit(64'h8000_0310, EBRK, 1'b0, 64'd9, t);
        wait_done();

        // asynchronous reset in DRAIN
        do_reset(0);
        commit(64'h8000_0030, EBRK, 1'b0, 64'h11, t);
        repeat (3) step();
        #2 reset = 1'b0;
        #1 chk_zero("rst_drain");

        // full run, then asynchronous reset in EXIT
        do_reset(0);
        commit(64'h8000_0040, EBRK, 1'b0, 64'h22, t);
        frozen = 64'(t + 1 + DR - rst_rel);
        expect_trap(64'h8000_0040, 64'h22, EBRK, 64'd1, t);
        wait_done();
        repeat (3) step();
        chk("frozen_cycle_cnt", cyc0, frozen);
        chk("exit_held", {63'd0, exit0}, 64'd1);
        chk("halt_held", {63'd0, halt0}, 64'd1);
        #2 reset = 1'b0;
        #1 chk_zero("rst_exit");

        // normal run after reset
        do_reset(0);
        commit(64'h8000_0050, NOP, 1'b0, 64'd0, t);
        commit(64'h8000_0054, EBRK, 1'b0, 64'd0, t);
        expect_trap(64'h8000_0054, 64'd0, EBRK, 64'd2, t);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trap_monitor.md
Name: trap_monitor

Overview:
- Retirement-side trap detector placed between the writeback/commit stage and the DEBUG simulation-exit block; generates DEBUG's exit, pc, a0 and inst inputs.
- Watches the in-order single-issue commit stream for ebreak, illegal instructions, an instruction-count limit and commit starvation (hang).
- On a trap it latches the terminating context, halts the core, drains for a fixed number of cycles, then raises exit.
- Also keeps cycle and instret counters for end-of-run statistics.

Parameters:
- TIMEOUT, 4096, consecutive cycles without a commit before a hang trap; 0 disables the watchdog.
- MAX_INSTR, 0, retired-instruction limit that triggers a trap; 0 disables the limit.
- DRAIN_CYCLES, 8, cycles spent in DRAIN before exit asserts; must be at least 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  64  pc of the retiring instruction.
- commit_inst  in  32  encoding of the retiring instruction.
- commit_illegal  in  1  retiring instruction was decoded illegal; qualified by commit_valid.
- rf_a0  in  64  architectural x10, read combinationally from the regfile.
- halt  out  1  stops fetch and commit while high.
- exit  out  1  to DEBUG.exit.
- pc  out  64  to DEBUG.pc.
- a0  out  64  to DEBUG.a0.
- inst  out  32  to DEBUG.inst.
- cycle_cnt  out  64  cycles since reset.
- instret_cnt  out  64  retired instructions since reset.

Behaviour:
- Reset: all outputs 0, state RUN, watchdog counter 0, last_pc and last_inst 0. Reset is asynchronous and returns to this state from any state, including DRAIN and EXIT.
- cycle_cnt: +1 every cycle out of reset, wraps at 2^64, freezes once state is EXIT.
- instret_cnt: +1 per commit_valid in RUN, wraps at 2^64.
- Commits are ignored outside RUN; the core must not commit while halt is high.
- FSM RUN -> DRAIN -> EXIT. EXIT is terminal until reset.
- RUN: on each commit, last_pc <= commit_pc and last_inst <= commit_inst. Trap sources are evaluated every cycle with this priority:
  1. Illegal: commit_valid & commit_illegal. Latch pc=commit_pc, inst=commit_inst, a0=64'h2.
  2. Ebreak: commit_valid & commit_inst==32'h00100073. Latch pc=commit_pc, inst=commit_inst, a0=rf_a0 sampled in the same cycle. rf_a0 already reflects all older commits because retirement is in order.
  3. Limit: MAX_INSTR!=0 and a commit makes instret_cnt+1==MAX_INSTR, and the commit is not an ebreak or illegal. Latch pc/inst of that commit, a0=64'h3.
  4. Hang: TIMEOUT!=0 and the watchdog reaches TIMEOUT. Latch pc=last_pc, inst=last_inst, a0=64'h1.
- Any trap: next state DRAIN, halt<=1 registered (high the cycle after detection), drain counter <= DRAIN_CYCLES-1.
- Watchdog: cleared on every commit, otherwise +1 per cycle in RUN, saturates at TIMEOUT. A commit in the same cycle the count would reach TIMEOUT clears it and no hang trap fires.
- DRAIN: halt=1, drain counter decrements, exit=0. At counter 0 move to EXIT. Latched pc/a0/inst do not change.
- EXIT: exit=1 held continuously, halt=1, pc/a0/inst stable.
- pc/a0/inst outputs hold 0 until a trap is latched, so DEBUG never sees partial data.
- Latency: trap commit at cycle T, halt at T+1, exit at T+1+DRAIN_CYCLES.

Decomposition:
- Package npc_trap_pkg:
  - EBREAK_INST = 32'h00100073.
  - Reason codes TRAP_HANG=1, TRAP_ILLEGAL=2, TRAP_LIMIT=3.
  - State enum {RUN, DRAIN, EXIT}.
  - XLEN=64.
- Sub-module trap_watchdog holds the parameterised saturating no-commit counter. Ports: clear, enable, expired.

Test Plan:
- ebreak with a0=0: commits at pc 0x80000000..0x8000000C, ebreak at 0x80000010, rf_a0=0 -> halt at T+1; exit at T+9 with pc=0x80000010, inst=0x00100073, a0=0; instret_cnt=5.
- ebreak with a0=1: same stream with rf_a0=1 -> exit with a0=1, reported as a bad trap; pc/inst as above.
- Illegal plus ebreak-encoded instruction in the same commit: commit_illegal=1, inst=0x00100073, pc=0x80000020 -> a0=2, pc=0x80000020.
- Hang, TIMEOUT=16: last commit pc=0x80000100, then 16 idle cycles -> a0=1, pc=0x80000100. A variant committing at idle cycle 15 gets no trap.
- Limit, MAX_INSTR=3: three non-trap commits -> a0=3, pc=third commit's pc, exit at +DRAIN_CYCLES+1; commits during DRAIN do not change instret_cnt.
- Reset mid-run: drop reset in DRAIN and again in EXIT -> all outputs 0 immediately (asynchronous); after release a normal ebreak run completes correctly.
